imu_frame_packer: RTL

- Sits directly downstream of bno085_controller.
- Consumes its quaternion and gyroscope sample pulses and packs them into fixed 19-byte frames.
- Frames leave on a byte-wide valid/ready stream that feeds the host-link transmitter (UART/SPI slave).
- Quaternion arrival triggers a frame; gyro is sampled from a shadow register; overload is absorbed by a one-deep pending slot with drop counting.

---
 rtl/imu_frame_packer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/imu_frame_packer.sv
// Packs bno085 quaternion + shadowed gyro samples into 19-byte sync/seq/flags/payload/check frames.
// Define IMU_FRAME_CRC8_EN to replace the additive checksum byte with CRC-8 (poly 0x07).
module imu_frame_packer #(
  parameter logic [7:0]  SYNC0  = 8'hAA,
  parameter logic [7:0]  SYNC1  = 8'h55,
  parameter int unsigned DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              quat_valid,
  input  logic [15:0]       quat_w,
  input  logic [15:0]       quat_x,
  input  logic [15:0]       quat_y,
  input  logic [15:0]       quat_z,
  input  logic              gyro_valid,
  input  logic [15:0]       gyro_x,
  input  logic [15:0]       gyro_y,
  input  logic [15:0]       gyro_z,
  input  logic              initialized,
  input  logic              error,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              frame_busy,
  output logic [DROP_W-1:0] drop_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;
  localparam logic [4:0] LAST_IDX = 5'd18;

  state_t            state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic [7:0]        seq_q, seq_d;
  logic [7:0]        acc_q, acc_d;
  logic [7:0]        payload_q [16];
  logic              pend_q, pend_d;
  logic [63:0]       pend_quat_q, pend_quat_d;
  logic [47:0]       gyro_q, gyro_d;
  logic              fresh_q, fresh_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic        accept;
  logic        last_accept;
  logic        snapshot;
  logic        store_pend;
  logic [63:0] snap_quat;
  logic [47:0] snap_gyro;
  logic [7:0]  snap_flags;
  logic [127:0] snap_vec;
  logic [7:0]  snap_bytes [16];
  logic [7:0]  cur_byte;
  logic [7:0]  acc_upd;
  logic [3:0]  pidx;

`ifdef IMU_FRAME_CRC8_EN
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  assign acc_upd = crc8_step(acc_q, cur_byte);
`else
  assign acc_upd = acc_q + cur_byte;
`endif

  // Payload bytes 2..17 of the frame, MSB-first from the packed snapshot word.
  assign snap_vec = {seq_q, snap_flags, snap_quat, snap_gyro};
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_unpack
      assign snap_bytes[gi] = snap_vec[127-8*gi -: 8];
    end
  endgenerate

  always_comb begin
    pidx = idx_q[3:0] - 4'd2;
    case (idx_q)
      5'd0:     cur_byte = SYNC0;
      5'd1:     cur_byte = SYNC1;
      LAST_IDX: cur_byte = acc_q;
      default:  cur_byte = payload_q[pidx];
    endcase
  end

  always_comb begin
    accept      = (state_q == ST_SEND) && out_ready;
    last_accept = accept && (idx_q == LAST_IDX);
    snapshot    = ((state_q == ST_IDLE) && quat_valid) || (state_q == ST_GAP);
    store_pend  = quat_valid && (state_q != ST_IDLE);
    snap_quat   = (state_q == ST_GAP) ? pend_quat_q : {quat_w, quat_x, quat_y, quat_z};
    // A gyro sample landing on the snapshot cycle goes straight into this frame.
    snap_gyro   = gyro_valid ? {gyro_x, gyro_y, gyro_z} : gyro_q;
    snap_flags  = {5'b00000, initialized, error, fresh_q | gyro_valid};

    state_d     = state_q;
    idx_d       = idx_q;
    seq_d       = seq_q;
    acc_d       = acc_q;
    pend_d      = pend_q;
    pend_quat_d = pend_quat_q;
    gyro_d      = gyro_q;
    fresh_d     = fresh_q;
    drop_d      = drop_q;

    case (state_q)
      ST_IDLE: if (quat_valid) state_d = ST_SEND;
      ST_SEND: if (last_accept) state_d = (pend_q || quat_valid) ? ST_GAP : ST_IDLE;
      ST_GAP:  state_d = ST_SEND;
      default: state_d = ST_IDLE;
    endcase

    if (snapshot) begin
      idx_d = 5'd0;
      acc_d = 8'h00;
    end else if (accept) begin
      idx_d = idx_q + 5'd1;
      if (idx_q >= 5'd2 && idx_q <= 5'd17) acc_d = acc_upd;
    end

    if (last_accept) seq_d = seq_q + 8'd1;

    // The gap cycle consumes the pending slot, so a sample arriving then is not a drop.
    if (state_q == ST_GAP) pend_d = 1'b0;
    if (store_pend) begin
      pend_d      = 1'b1;
      pend_quat_d = {quat_w, quat_x, quat_y, quat_z};
      if (pend_q && (state_q != ST_GAP) && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);
    end

    if (gyro_valid) begin
      gyro_d  = {gyro_x, gyro_y, gyro_z};
      fresh_d = 1'b1;
    end else if (snapshot) begin
      fresh_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 5'd0;
      seq_q       <= 8'h00;
      acc_q       <= 8'h00;
      pend_q      <= 1'b0;
      pend_quat_q <= '0;
      gyro_q      <= '0;
      fresh_q     <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      seq_q       <= seq_d;
      acc_q       <= acc_d;
      pend_q      <= pend_d;
      pend_quat_q <= pend_quat_d;
      gyro_q      <= gyro_d;
      fresh_q     <= fresh_d;
      drop_q      <= drop_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) payload_q[i] <= 8'h00;
    end else if (snapshot) begin
      payload_q <= snap_bytes;
    end
  end

  assign out_valid  = (state_q == ST_SEND);
  assign out_data   = out_valid ? cur_byte : 8'h00;
  assign frame_busy = (state_q != ST_IDLE);
  assign drop_count = drop_q;

endmodule
